// File: rtl/sysbus_rr_scheduler.sv
// Round-robin owner of the single Sysbus Top port.
// One grant runs one whole read or write line transfer.
module sysbus_rr_scheduler #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int NPORTS     = 2,
  parameter int BEATS      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NPORTS-1:0]            rq_valid,
  input  logic [NPORTS-1:0]            rq_write,
  input  logic [NPORTS*DATA_WIDTH-1:0] rq_addr,
  input  logic [NPORTS*DATA_WIDTH-1:0] rq_wdata,
  output logic [NPORTS-1:0]            rq_grant,
  output logic [NPORTS-1:0]            rq_wnext,
  output logic [NPORTS-1:0]            rs_valid,
  output logic [DATA_WIDTH-1:0]        rs_data,
  output logic [NPORTS-1:0]            rq_done,
  output logic [DATA_WIDTH-1:0]        req,
  output logic [TAG_WIDTH-1:0]         reqtag,
  output logic                         reqcyc,
  input  logic                         reqack,
  input  logic [DATA_WIDTH-1:0]        resp,
  input  logic [TAG_WIDTH-1:0]         resptag,
  input  logic                         respcyc,
  output logic                         respack,
  output logic                         err_tag
);

  localparam int ID_W  = $clog2(NPORTS);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RESP,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  owner, owner_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic              found;
  logic [ID_W-1:0]   pick;
  logic              own_wr;
  logic [NPORTS-1:0] own_oh;
  logic [TAG_WIDTH-1:0] own_tag;
  logic [TAG_WIDTH-1:0] rd_tag;
  logic              tag_ok;

  assign rs_data = resp;

  // first requester at or after ptr; scanned downward so the nearest wins
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NPORTS;
      if (rq_valid[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  // owner-derived tag, one-hot and response match
  always_comb begin
    own_wr  = rq_write[owner];
    own_oh  = NPORTS'(1) << owner;
    rd_tag  = '0;
    rd_tag[ID_W-1:0] = owner;
    own_tag = rd_tag;
    own_tag[TAG_WIDTH-1] = own_wr;
    tag_ok  = (resptag == rd_tag);
  end

  // state register; reset abandons any burst in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next state and bus outputs
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    rq_grant  = '0;
    rq_wnext  = '0;
    rs_valid  = '0;
    rq_done   = '0;
    req       = '0;
    reqtag    = '0;
    reqcyc    = 1'b0;
    respack   = 1'b0;
    err_tag   = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = pick;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        rq_grant = own_oh;
        reqcyc   = 1'b1;
        req      = rq_addr[owner*DATA_WIDTH +: DATA_WIDTH];
        reqtag   = own_tag;
        if (reqack) begin
          cnt_nxt   = '0;
          state_nxt = own_wr ? WDATA : RESP;
        end
      end
      WDATA: begin
        rq_grant = own_oh;
        reqcyc   = 1'b1;
        req      = rq_wdata[owner*DATA_WIDTH +: DATA_WIDTH];
        reqtag   = own_tag;
        if (reqack) begin
          rq_wnext = own_oh;
          cnt_nxt  = cnt + 1'b1;
          if (cnt == LAST) state_nxt = DONE;
        end
      end
      RESP: begin
        rq_grant = own_oh;
        respack  = respcyc;
        if (respcyc) begin
          if (tag_ok) begin
            rs_valid = own_oh;
            cnt_nxt  = cnt + 1'b1;
            if (cnt == LAST) state_nxt = DONE;
          end else begin
            err_tag = 1'b1;
          end
        end
      end
      DONE: begin
        rq_done   = own_oh;
        cnt_nxt   = '0;
        ptr_nxt   = (int'(owner) == NPORTS - 1) ? '0 : owner + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sysbus_rr_scheduler.sv
// Randomized bench for sysbus_rr_scheduler.
// Requesters and Sysbus slave are modelled at transaction level.
module tb_sysbus_rr_scheduler;

  localparam int NP    = 2;
  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int BEATS = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NP-1:0]    rq_valid, rq_write;
  logic [NP*DW-1:0] rq_addr, rq_wdata;
  logic [NP-1:0]    rq_grant, rq_wnext, rs_valid, rq_done;
  logic [DW-1:0]    rs_data, req, resp;
  logic [TW-1:0]    reqtag, resptag;
  logic             reqcyc, reqack, respcyc, respack, err_tag;

  sysbus_rr_scheduler #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .NPORTS(NP), .BEATS(BEATS)
  ) dut (
    .clk(clk), .reset(reset),
    .rq_valid(rq_valid), .rq_write(rq_write),
    .rq_addr(rq_addr), .rq_wdata(rq_wdata),
    .rq_grant(rq_grant), .rq_wnext(rq_wnext),
    .rs_valid(rs_valid), .rs_data(rs_data),
    .rq_done(rq_done), .req(req), .reqtag(reqtag),
    .reqcyc(reqcyc), .reqack(reqack), .resp(resp),
    .resptag(resptag), .respcyc(respcyc),
    .respack(respack), .err_tag(err_tag)
  );

  int n_chk = 0;
  int n_fail = 0;
  int ptr_m = 0;
  int req_pct = 30;

  logic [NP-1:0] pv, pw, prev_v;
  logic [DW-1:0] pa [NP];
  logic [DW-1:0] pd [NP][BEATS];
  int            wb [NP];

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic finish_tb();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  endtask

  task automatic abort_tb(string tag);
    check(tag, 64'd0, 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $fatal(1, "bound expired");
  endtask

  function automatic logic [NP-1:0] oh(int i);
    return NP'(1) << i;
  endfunction

  function automatic int rr_pick(int p, logic [NP-1:0] v);
    for (int k = 0; k < NP; k++)
      if (v[(p + k) % NP]) return (p + k) % NP;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      rq_valid[i] = pv[i];
      rq_write[i] = pw[i];
      rq_addr[i*DW +: DW]  = pa[i];
      rq_wdata[i*DW +: DW] = pd[i][wb[i] < BEATS ? wb[i] : BEATS-1];
    end
  endtask

  task automatic new_req(int i, logic w, logic [DW-1:0] a);
    pv[i] = 1'b1;
    pw[i] = w;
    pa[i] = a;
    wb[i] = 0;
    for (int b = 0; b < BEATS; b++) pd[i][b] = {$urandom, $urandom};
  endtask

  // advance to the next negedge and present fresh idle bus inputs
  task automatic cyc();
    @(negedge clk);
    prev_v = rq_valid;
    for (int i = 0; i < NP; i++)
      if (!pv[i] && $urandom_range(99) < req_pct)
        new_req(i, 1'($urandom_range(1)), {$urandom, $urandom});
    drive();
    reqack  = 1'b0;
    respcyc = 1'b0;
    resp    = {$urandom, $urandom};
    resptag = TW'($urandom);
  endtask

  // k0=0: first cycle is the IDLE bubble after DONE
  task automatic wait_grant(int k0, output int o);
    int e;
    o = -1;
    for (int k = k0; k < 100 && o < 0; k++) begin
      cyc();
      if (k >= 4 && pv == '0) begin
        new_req($urandom_range(NP-1), 1'($urandom_range(1)),
                {$urandom, $urandom});
        drive();
      end
      respcyc = 1'($urandom_range(1));
      #1;
      e = (k == 0) ? -1 : rr_pick(ptr_m, prev_v);
      check("arb_grant", rq_grant, e < 0 ? '0 : oh(e));
      check("arb_reqcyc", reqcyc, e >= 0);
      check("idle_respack", respack, 0);
      check("idle_rsvalid", rs_valid, 0);
      check("idle_errtag", err_tag, 0);
      check("idle_done", rq_done, 0);
      check("rsdata_mirror", rs_data, resp);
      if (e >= 0) o = e;
    end
    if (o < 0) abort_tb("grant_timeout");
  endtask

  task automatic run_txn(int o);
    logic [TW-1:0] et;
    logic acked, bad;
    int n, b;
    et = TW'(o);
    if (pw[o]) et[TW-1] = 1'b1;
    acked = 1'b0;
    n = 0;
    while (!acked && n < 100) begin
      if (n > 0) begin
        cyc();
        reqack  = 1'($urandom_range(1));
        respcyc = 1'($urandom_range(1));
        #1;
      end
      n++;
      check("addr_reqcyc", reqcyc, 1);
      check("addr_req", req, pa[o]);
      check("addr_tag", reqtag, et);
      check("addr_grant", rq_grant, oh(o));
      check("addr_respack", respack, 0);
      check("addr_rsvalid", rs_valid, 0);
      check("addr_errtag", err_tag, 0);
      acked = reqack;
    end
    if (!acked) abort_tb("addr_timeout");
    b = 0;
    n = 0;
    if (pw[o]) begin
      while (b < BEATS && n < 200) begin
        cyc();
        reqack = ($urandom_range(99) < 50);
        #1;
        check("wr_req", req, pd[o][b]);
        check("wr_tag", reqtag, et);
        check("wr_reqcyc", reqcyc, 1);
        check("wr_wnext", rq_wnext, reqack ? oh(o) : '0);
        check("wr_grant", rq_grant, oh(o));
        check("wr_done", rq_done, 0);
        if (reqack) begin
          b++;
          wb[o] = b;
        end
        n++;
      end
    end else begin
      while (b < BEATS && n < 200) begin
        cyc();
        bad = 1'b0;
        if ($urandom_range(99) < 70) begin
          respcyc = 1'b1;
          bad = ($urandom_range(99) < 20);
          resptag = TW'(o);
          if (bad) begin
            if ($urandom_range(1) == 1) resptag = TW'((o + 1) % NP);
            else resptag[TW-1] = 1'b1;
          end
        end
        #1;
        check("rd_respack", respack, respcyc);
        check("rd_data", rs_data, resp);
        check("rd_rsvalid", rs_valid,
              (respcyc && !bad) ? oh(o) : '0);
        check("rd_errtag", err_tag, respcyc && bad);
        check("rd_reqcyc", reqcyc, 0);
        check("rd_grant", rq_grant, oh(o));
        check("rd_done", rq_done, 0);
        if (respcyc && !bad) b++;
        n++;
      end
    end
    if (b < BEATS) abort_tb("beat_timeout");
    cyc();
    respcyc = 1'($urandom_range(1));
    #1;
    check("done_pulse", rq_done, oh(o));
    check("done_grant", rq_grant, 0);
    check("done_reqcyc", reqcyc, 0);
    check("done_respack", respack, 0);
    check("done_rsvalid", rs_valid, 0);
    pv[o] = 1'b0;
    drive();
    ptr_m = (o + 1) % NP;
  endtask

  initial begin
    int o, last;
    reset   = 1'b1;
    pv      = '0;
    pw      = '0;
    prev_v  = '0;
    for (int i = 0; i < NP; i++) begin
      pa[i] = '0;
      wb[i] = 0;
      for (int b = 0; b < BEATS; b++) pd[i][b] = '0;
    end
    drive();
    reqack  = 1'b0;
    respcyc = 1'b1;
    resp    = 64'h1234;
    resptag = '0;
    #12;
    check("rst_grant", rq_grant, 0);
    check("rst_reqcyc", reqcyc, 0);
    check("rst_respack", respack, 0);
    check("rst_rsvalid", rs_valid, 0);
    check("rst_done", rq_done, 0);
    check("rst_wnext", rq_wnext, 0);
    check("rst_errtag", err_tag, 0);
    check("rst_req", req, 0);
    check("rst_reqtag", reqtag, 0);
    @(negedge clk);
    reset = 1'b0;

    last = -1;
    for (int t = 0; t < 40; t++) begin
      if (t == 20) req_pct = 100;
      wait_grant(t == 0 ? 1 : 0, o);
      if (t > 20) check("alternate", o, (last + 1) % NP);
      run_txn(o);
      last = o;
    end

    req_pct = 0;
    while (pv != '0) begin
      wait_grant(0, o);
      run_txn(o);
    end

    new_req(0, 1'b0, 64'h1000);
    wait_grant(0, o);
    check("dir_owner0", o, 0);
    run_txn(0);

    new_req(1, 1'b0, 64'h2040);
    wait_grant(0, o);
    check("dir_owner1", o, 1);
    cyc();
    reqack = 1'b1;
    #1;
    check("abort_tag", reqtag, 1);
    check("abort_req", req, 64'h2040);
    for (int b = 0; b < 5; b++) begin
      cyc();
      respcyc = 1'b1;
      resptag = TW'(1);
      #1;
      check("abort_beat", rs_valid, 2'b10);
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_reqcyc", reqcyc, 0);
    check("async_grant", rq_grant, 0);
    check("async_respack", respack, 0);
    check("async_rsvalid", rs_valid, 0);
    pv = '0;
    drive();
    ptr_m = 0;
    cyc();
    reset = 1'b0;
    new_req(0, 1'b1, {$urandom, $urandom});
    new_req(1, 1'b1, {$urandom, $urandom});
    drive();
    respcyc = 1'b1;
    resptag = '0;
    #1;
    check("idle_resp_ack", respack, 0);
    check("idle_resp_rsv", rs_valid, 0);
    check("idle_resp_err", err_tag, 0);
    check("idle_resp_gnt", rq_grant, 0);
    wait_grant(1, o);
    check("ptr_after_rst", o, 0);
    run_txn(o);
    wait_grant(0, o);
    check("second_owner", o, 1);
    run_txn(o);
    finish_tb();
  end

endmodule
